s298_bist: RTL and testbench
============================

S298_BIST -- requirements
Module: s298_bist

Interface
- REQ-001: Parameter PATTERNS, default 255. Number of RUN cycles, range 1..65535.
- REQ-002: Parameter INIT_CYC, default 4. Number of CUT-clear cycles, range 1..255.
- REQ-003: Parameter GOLDEN, default 16'h0000. Expected signature.
- REQ-004: Port CK, input, 1 bit. Single clock; all state updates on the rising edge.
- REQ-005: Port RN, input, 1 bit. Reset, asynchronous, active-low.
- REQ-006: Port START, input, 1 bit. Test-start request, sampled on the rising edge of CK.
- REQ-007: Ports G66, G67, G117, G118, G132, G133, input, 1 bit each. Responses from the s298 under test.
- REQ-008: Ports G0, G1, G2, output, 1 bit each. Stimulus to the s298 under test; G0 high clears the CUT.
- REQ-009: Port BUSY, output, 1 bit. Test in progress.
- REQ-010: Port DONE, output, 1 bit. Test complete; holds until the next START or reset.
- REQ-011: Port SIGNATURE, output, 16 bits. MISR contents.
- REQ-012: Port PASS, output, 1 bit. Signature matches GOLDEN; valid only while DONE=1.

Function
- REQ-013: The block SHALL implement an FSM with states IDLE, INIT, RUN, FLUSH and DONE.
- REQ-014: FSM transitions SHALL be:
  - IDLE -> INIT on START=1.
  - INIT -> RUN after INIT_CYC cycles.
  - RUN -> FLUSH after PATTERNS cycles.
  - FLUSH -> DONE after 1 cycle.
  - DONE -> INIT on START=1.
  - Otherwise the state holds.
- REQ-015: START SHALL be ignored in INIT, RUN and FLUSH.
- REQ-016: In IDLE and DONE, the outputs SHALL be {G2,G1,G0}=3'b000.
- REQ-017: In INIT, the outputs SHALL be G0=1, G1=0, G2=0.
- REQ-018: On entry to INIT, the LFSR SHALL load 8'h01, the MISR SHALL load 16'hFFFF, and the counters SHALL clear.
- REQ-019: In RUN, the outputs SHALL be {G2,G1,G0}=lfsr[2:0], registered.
- REQ-020: Each RUN cycle, the LFSR SHALL advance as lfsr <= {lfsr[6:0], lfsr[7]^lfsr[5]^lfsr[4]^lfsr[3]}.
- REQ-021: The LFSR SHALL never reach zero, whatever the value of PATTERNS.
- REQ-022: In RUN and FLUSH, the MISR SHALL compact one response word per cycle:
  - next = {misr[14:0],1'b0} ^ (misr[15] ? 16'h1021 : 16'h0) ^ {10'b0, G133,G132,G118,G117,G67,G66}.
- REQ-023: FLUSH SHALL supply exactly one extra compaction, covering the one-cycle CUT register latency; the outputs in FLUSH SHALL be {G2,G1,G0}=3'b000.
- REQ-024: Total compactions per test SHALL be PATTERNS+1.
- REQ-025: The MISR SHALL hold in IDLE, INIT and DONE.
- REQ-026: BUSY SHALL be 1 exactly in INIT, RUN and FLUSH.
- REQ-027: DONE SHALL be 1 exactly in DONE.
- REQ-028: BUSY and DONE SHALL never be 1 together.
- REQ-029: SIGNATURE SHALL equal the MISR at all times.
- REQ-030: DONE SHALL rise in the cycle after the FLUSH compaction; the latency from the START edge to DONE=1 SHALL be INIT_CYC+PATTERNS+2 cycles.
- REQ-031: The RUN counter SHALL be 16 bits; a PATTERNS=1 test SHALL run exactly one RUN cycle.
- REQ-032: START asserted in DONE SHALL clear DONE on the next edge and restart the test from fresh seeds.

Reset
- REQ-033: RN=0 SHALL force asynchronously: state IDLE, LFSR 8'h01, MISR 16'hFFFF, counters 0, G0=G1=G2=0, BUSY=0, DONE=0, PASS=0, SIGNATURE=16'hFFFF.
- REQ-034: Reset asserted mid-test SHALL abort the test with no residual state; a START after release SHALL behave as a first test.

Configuration
- REQ-035: Macro S298_BIST_GOLDEN_CMP_EN defined: PASS SHALL be registered as (MISR==GOLDEN) on entry to DONE, and cleared on leaving DONE.
- REQ-036: Macro S298_BIST_GOLDEN_CMP_EN undefined: PASS SHALL be tied to 0, GOLDEN SHALL be unused, and no comparator SHALL be built.

Structure
- REQ-037: Package s298_bist_pkg SHALL hold:
  - the state enum;
  - LFSR_SEED=8'h01;
  - MISR_SEED=16'hFFFF;
  - MISR_POLY=16'h1021;
  - the LFSR tap mask.
- REQ-038: One sub-module SHALL exist: s298_bist_misr, a 16-bit MISR with ports clock, reset, load, enable, 6-bit data in, and signature out.
- REQ-039: The FSM, counters and LFSR SHALL reside in s298_bist.

Verification
- REQ-040: Reset: RN=0 mid-RUN -> the next sampled values SHALL be BUSY=0, DONE=0, SIGNATURE=16'hFFFF, {G2,G1,G0}=0.
- REQ-041: Init phase: with INIT_CYC=4, a START pulse -> G0=1 SHALL be seen for exactly 4 cycles, then the first RUN {G2,G1,G0} values SHALL be 001, 010, 100.
- REQ-042: MISR arithmetic: PATTERNS=1 with all responses held 0 -> SIGNATURE=16'hCF9F at DONE, via the intermediate value 16'hEFDF.
- REQ-043: Latency: INIT_CYC=4, PATTERNS=255 -> DONE=1 exactly 261 cycles after the START edge; START pulses during BUSY SHALL have no effect.
- REQ-044: Comparator: with the macro defined and GOLDEN=16'hCF9F (zero-response setup) -> PASS=1 at DONE. With GOLDEN=16'h0000 -> PASS=0. With the macro undefined -> PASS=0 always.
- REQ-045: Restart: START in DONE -> DONE falls next cycle, G0=1 for INIT_CYC cycles, and the second signature SHALL equal the first for identical responses.

Source files
------------

// File: rtl/s298_bist_pkg.sv
// Shared types and constants for the s298 BIST controller: FSM states, LFSR/MISR seeds,
// polynomial and the LFSR feedback tap mask.
package s298_bist_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_INIT  = 3'd1,
    ST_RUN   = 3'd2,
    ST_FLUSH = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

  localparam logic [7:0]  LFSR_SEED = 8'h01;
  localparam logic [7:0]  LFSR_TAPS = 8'hB8;   // bits 7,5,4,3
  localparam logic [15:0] MISR_SEED = 16'hFFFF;
  localparam logic [15:0] MISR_POLY = 16'h1021;

  function automatic logic [7:0] lfsr_next(input logic [7:0] cur);
    return {cur[6:0], ^(cur & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/s298_bist_misr.sv
// 16-bit multiple-input signature register compacting one 6-bit CUT response word per enabled cycle.
module s298_bist_misr
  import s298_bist_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        load_i,
  input  logic        en_i,
  input  logic [5:0]  data_i,
  output logic [15:0] sig_o
);

  logic [15:0] sig_q;
  logic [15:0] sig_d;

  always_comb begin
    sig_d = sig_q;
    if (load_i) begin
      sig_d = MISR_SEED;
    end else if (en_i) begin
      sig_d = {sig_q[14:0], 1'b0} ^ (sig_q[15] ? MISR_POLY : 16'h0000) ^ {10'd0, data_i};
    end else begin
      sig_d = sig_q;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sig_q <= MISR_SEED;
    end else begin
      sig_q <= sig_d;
    end
  end

  assign sig_o = sig_q;

endmodule

// File: rtl/s298_bist.sv
// BIST controller for an s298 CUT: clears the CUT, drives LFSR patterns, compacts responses.
// Optional golden-signature comparator enabled by macro S298_BIST_GOLDEN_CMP_EN.
module s298_bist
  import s298_bist_pkg::*;
#(
  parameter int unsigned PATTERNS = 255,
  parameter int unsigned INIT_CYC = 4,
  parameter logic [15:0] GOLDEN   = 16'h0000
) (
  input  logic        CK,
  input  logic        RN,
  input  logic        START,
  input  logic        G66,
  input  logic        G67,
  input  logic        G117,
  input  logic        G118,
  input  logic        G132,
  input  logic        G133,
  output logic        G0,
  output logic        G1,
  output logic        G2,
  output logic        BUSY,
  output logic        DONE,
  output logic [15:0] SIGNATURE,
  output logic        PASS
);

  localparam logic [15:0] INIT_LAST = 16'(INIT_CYC - 1);
  localparam logic [15:0] RUN_LAST  = 16'(PATTERNS - 1);

  state_e      state_q;
  logic [15:0] cnt_q;
  logic [7:0]  lfsr_q;
  logic [2:0]  g_q;
  logic        busy_q;
  logic        done_q;
  logic        pass_q;
  logic        restart_s;
  logic        misr_en_s;
  logic        cmp_s;

  assign restart_s = START && ((state_q == ST_IDLE) || (state_q == ST_DONE));
  assign misr_en_s = (state_q == ST_RUN) || (state_q == ST_FLUSH);

`ifdef S298_BIST_GOLDEN_CMP_EN
  assign cmp_s = (SIGNATURE == GOLDEN);
`else
  assign cmp_s = 1'b0;
`endif

  s298_bist_misr u_misr (
    .clk_i  (CK),
    .rst_ni (RN),
    .load_i (restart_s),
    .en_i   (misr_en_s),
    .data_i ({G133, G132, G118, G117, G67, G66}),
    .sig_o  (SIGNATURE)
  );

  // Outputs are registered from the current state, so they trail the state by one cycle.
  always_ff @(posedge CK or negedge RN) begin
    if (!RN) begin
      state_q <= ST_IDLE;
      cnt_q   <= 16'd0;
      lfsr_q  <= LFSR_SEED;
      g_q     <= 3'b000;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
    end else begin
      g_q    <= 3'b000;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      pass_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (START) begin
            state_q <= ST_INIT;
            cnt_q   <= 16'd0;
            lfsr_q  <= LFSR_SEED;
          end
        end
        ST_INIT: begin
          g_q    <= 3'b001;
          busy_q <= 1'b1;
          if (cnt_q == INIT_LAST) begin
            state_q <= ST_RUN;
            cnt_q   <= 16'd0;
          end else begin
            cnt_q <= cnt_q + 16'd1;
          end
        end
        ST_RUN: begin
          g_q    <= lfsr_q[2:0];
          busy_q <= 1'b1;
          lfsr_q <= lfsr_next(lfsr_q);
          if (cnt_q == RUN_LAST) begin
            state_q <= ST_FLUSH;
            cnt_q   <= 16'd0;
          end else begin
            cnt_q <= cnt_q + 16'd1;
          end
        end
        ST_FLUSH: begin
          busy_q  <= 1'b1;
          state_q <= ST_DONE;
        end
        ST_DONE: begin
          if (START) begin
            state_q <= ST_INIT;
            cnt_q   <= 16'd0;
            lfsr_q  <= LFSR_SEED;
          end else begin
            done_q <= 1'b1;
            pass_q <= cmp_s;
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign G0   = g_q[0];
  assign G1   = g_q[1];
  assign G2   = g_q[2];
  assign BUSY = busy_q;
  assign DONE = done_q;
  assign PASS = pass_q;

endmodule

// File: tb/tb_s298_bist.sv
// Self-checking bench for s298_bist: two instances (long and one-pattern runs) checked per cycle
// against a behavioural model of the BIST sequence.
module tb_s298_bist;

  localparam int PA = 255;
  localparam int IA = 4;
  localparam int PB = 1;
  localparam int IB = 4;
  localparam logic [15:0] GOLD_A = 16'h0000;
  localparam logic [15:0] GOLD_B = 16'hCF9F;
`ifdef S298_BIST_GOLDEN_CMP_EN
  localparam bit CMP_EN = 1'b1;
`else
  localparam bit CMP_EN = 1'b0;
`endif

  logic CK = 1'b0;
  logic RN = 1'b0;
  logic start_a = 1'b0;
  logic start_b = 1'b0;
  logic [5:0] resp_a = 6'd0;
  logic [5:0] resp_b = 6'd0;
  logic [2:0] g_a, g_b;
  logic busy_a, busy_b, done_a, done_b, pass_a, pass_b;
  logic [15:0] sig_a, sig_b;

  int n_tests = 0;
  int n_fail = 0;
  logic [15:0] sig_hist[$];
  logic [15:0] first_sig_b;

  always #5 CK = ~CK;

  s298_bist #(.PATTERNS(PA), .INIT_CYC(IA), .GOLDEN(GOLD_A)) dut_a (
    .CK(CK), .RN(RN), .START(start_a),
    .G66(resp_a[0]), .G67(resp_a[1]), .G117(resp_a[2]),
    .G118(resp_a[3]), .G132(resp_a[4]), .G133(resp_a[5]),
    .G0(g_a[0]), .G1(g_a[1]), .G2(g_a[2]),
    .BUSY(busy_a), .DONE(done_a), .SIGNATURE(sig_a), .PASS(pass_a)
  );

  s298_bist #(.PATTERNS(PB), .INIT_CYC(IB), .GOLDEN(GOLD_B)) dut_b (
    .CK(CK), .RN(RN), .START(start_b),
    .G66(resp_b[0]), .G67(resp_b[1]), .G117(resp_b[2]),
    .G118(resp_b[3]), .G132(resp_b[4]), .G133(resp_b[5]),
    .G0(g_b[0]), .G1(g_b[1]), .G2(g_b[2]),
    .BUSY(busy_b), .DONE(done_b), .SIGNATURE(sig_b), .PASS(pass_b)
  );

  // Signature compaction as polynomial arithmetic: multiply by x modulo x^16+x^12+x^5+1, add data.
  function automatic logic [15:0] misr_ref(input logic [15:0] m, input logic [5:0] d);
    logic [16:0] t;
    t = {m, 1'b0};
    if (t[16]) t = t ^ 17'h11021;
    return t[15:0] ^ {10'd0, d};
  endfunction

  function automatic logic [7:0] lfsr_step(input logic [7:0] l);
    return {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
  endfunction

  // Runs one complete test on the selected instance, starting with START on the next edge.
  task automatic run_test(input bit sel, input bit zero, input bit pulses, output logic [15:0] sig_out);
    int p, ic, last;
    logic [15:0] m, gold, os;
    logic [7:0] l;
    logic [2:0] eg, og;
    logic eb, ed, ep, ob, od, op;
    p = sel ? PB : PA;
    ic = sel ? IB : IA;
    gold = sel ? GOLD_B : GOLD_A;
    last = ic + p + 2;
    m = 16'hFFFF;
    l = 8'h01;
    os = 16'h0000;
    sig_hist.delete();
    if (sel) start_b = 1'b1; else start_a = 1'b1;
    @(negedge CK);
    start_a = 1'b0;
    start_b = 1'b0;
    if (sel) resp_b = zero ? 6'd0 : 6'($urandom);
    else resp_a = zero ? 6'd0 : 6'($urandom);
    for (int n = 1; n <= last + 2; n++) begin
      @(negedge CK);
      if (n >= ic + 1 && n <= ic + p + 1) m = misr_ref(m, sel ? resp_b : resp_a);
      eb = (n <= ic + p + 1);
      ed = (n >= last);
      if (n <= ic) eg = 3'b001;
      else if (n <= ic + p) begin
        eg = l[2:0];
        l = lfsr_step(l);
      end else eg = 3'b000;
      ep = ed && CMP_EN && (m == gold);
      og = sel ? g_b : g_a;
      ob = sel ? busy_b : busy_a;
      od = sel ? done_b : done_a;
      op = sel ? pass_b : pass_a;
      os = sel ? sig_b : sig_a;
      sig_hist.push_back(os);
      n_tests++;
      if (og !== eg) begin n_fail++; $display("FAIL stim dut%0d n=%0d got %b want %b", sel, n, og, eg); end
      n_tests++;
      if (ob !== eb) begin n_fail++; $display("FAIL busy dut%0d n=%0d got %b want %b", sel, n, ob, eb); end
      n_tests++;
      if (od !== ed) begin n_fail++; $display("FAIL done dut%0d n=%0d got %b want %b", sel, n, od, ed); end
      n_tests++;
      if (os !== m) begin n_fail++; $display("FAIL sig dut%0d n=%0d got %h want %h", sel, n, os, m); end
      n_tests++;
      if (op !== ep) begin n_fail++; $display("FAIL pass dut%0d n=%0d got %b want %b", sel, n, op, ep); end
      if (sel) resp_b = zero ? 6'd0 : 6'($urandom);
      else resp_a = zero ? 6'd0 : 6'($urandom);
      if (pulses && (n == 2 || n == ic + p / 2 || n == ic + p)) begin
        if (sel) start_b = 1'b1; else start_a = 1'b1;
      end else begin
        start_a = 1'b0;
        start_b = 1'b0;
      end
    end
    sig_out = os;
  endtask

  task automatic test_reset();
    RN = 1'b0;
    @(negedge CK);
    n_tests++;
    if ({busy_a, done_a, pass_a, g_a, busy_b, done_b, pass_b, g_b} !== 12'd0) begin
      n_fail++;
      $display("FAIL reset_ctrl got %b want 0", {busy_a, done_a, pass_a, g_a, busy_b, done_b, pass_b, g_b});
    end
    n_tests++;
    if (sig_a !== 16'hFFFF || sig_b !== 16'hFFFF) begin
      n_fail++;
      $display("FAIL reset_sig got %h/%h want ffff", sig_a, sig_b);
    end
    RN = 1'b1;
    @(negedge CK);
  endtask

  task automatic test_init_latency();
    logic [15:0] s;
    run_test(1'b0, 1'b0, 1'b1, s);
    n_tests++;
    if (sig_hist[IA + PA + 1] !== s || done_a !== 1'b1) begin
      n_fail++;
      $display("FAIL latency_done got done=%b want 1", done_a);
    end
  endtask

  task automatic test_misr_arith();
    run_test(1'b1, 1'b1, 1'b0, first_sig_b);
    n_tests++;
    if (sig_hist[IB] !== 16'hEFDF) begin
      n_fail++;
      $display("FAIL misr_mid got %h want efdf", sig_hist[IB]);
    end
    n_tests++;
    if (first_sig_b !== 16'hCF9F) begin
      n_fail++;
      $display("FAIL misr_final got %h want cf9f", first_sig_b);
    end
  endtask

  task automatic test_comparator();
    n_tests++;
    if (pass_b !== CMP_EN) begin
      n_fail++;
      $display("FAIL pass_golden got %b want %b", pass_b, CMP_EN);
    end
    n_tests++;
    if (pass_a !== (CMP_EN && sig_a == GOLD_A)) begin
      n_fail++;
      $display("FAIL pass_zero_golden got %b want %b", pass_a, CMP_EN && sig_a == GOLD_A);
    end
  endtask

  task automatic test_restart();
    logic [15:0] s2;
    repeat (3) begin
      @(negedge CK);
      n_tests++;
      if (done_b !== 1'b1) begin n_fail++; $display("FAIL done_hold got %b want 1", done_b); end
    end
    run_test(1'b1, 1'b1, 1'b0, s2);
    n_tests++;
    if (s2 !== first_sig_b) begin
      n_fail++;
      $display("FAIL restart_sig got %h want %h", s2, first_sig_b);
    end
  endtask

  task automatic test_reset_mid_run();
    logic [15:0] s;
    start_a = 1'b1;
    @(negedge CK);
    start_a = 1'b0;
    repeat (50) begin
      resp_a = 6'($urandom);
      @(negedge CK);
    end
    RN = 1'b0;
    #1;
    n_tests++;
    if ({busy_a, done_a, pass_a, g_a} !== 6'd0) begin
      n_fail++;
      $display("FAIL midrst_ctrl got %b want 0", {busy_a, done_a, pass_a, g_a});
    end
    n_tests++;
    if (sig_a !== 16'hFFFF) begin
      n_fail++;
      $display("FAIL midrst_sig got %h want ffff", sig_a);
    end
    @(negedge CK);
    RN = 1'b1;
    @(negedge CK);
    run_test(1'b0, 1'b0, 1'b0, s);
  endtask

  initial begin
    test_reset();
    test_init_latency();
    test_misr_arith();
    test_comparator();
    test_restart();
    test_reset_mid_run();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
